// File: rtl/counter_preset_seq_if.sv
// rtl/counter_preset_seq_if.sv - command/config/status bundle between a host and counter_preset_seq
interface counter_preset_seq_if #(
  parameter int WIDTH  = 8,
  parameter int LEN_W  = 8,
  parameter int LOOP_W = 4
);
  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  cfg_preset;
  logic [LEN_W-1:0]  cfg_count_len;
  logic [LEN_W-1:0]  cfg_pause_len;
  logic [LOOP_W-1:0] cfg_loops;
  logic              count_up;
  logic              load;
  logic [WIDTH-1:0]  data_preset;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, cfg_preset, cfg_count_len, cfg_pause_len, cfg_loops,
    input  count_up, load, data_preset, busy, done
  );

  modport slave (
    input  start, abort, cfg_preset, cfg_count_len, cfg_pause_len, cfg_loops,
    output count_up, load, data_preset, busy, done
  );
endinterface

// File: rtl/counter_preset_seq.sv
// rtl/counter_preset_seq.sv - load/count/pause/loop program sequencer driving counter_preset
module counter_preset_seq #(
  parameter int WIDTH  = 8,
  parameter int LEN_W  = 8,
  parameter int LOOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  counter_preset_seq_if.slave seq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [WIDTH-1:0]  preset_q, preset_d;
  logic [LEN_W-1:0]  count_len_q, count_len_d;
  logic [LEN_W-1:0]  pause_len_q, pause_len_d;
  logic [LOOP_W-1:0] loops_q, loops_d;

  logic              count_up_q, count_up_d;
  logic              load_q, load_d;
  logic [WIDTH-1:0]  data_preset_q, data_preset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              end_of_loop;
  logic [LOOP_W-1:0] loop_inc;
  logic [LOOP_W-1:0] loops_eff;

  // Loop count of 0 behaves as a single pass.
  assign loops_eff = (loops_q == '0) ? LOOP_W'(1) : loops_q;
  assign loop_inc  = loop_q + LOOP_W'(1);

  // Next state, length/loop counters, shadow config, and next registered outputs.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    loop_d      = loop_q;
    preset_d    = preset_q;
    count_len_d = count_len_q;
    pause_len_d = pause_len_q;
    loops_d     = loops_q;
    end_of_loop = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (seq.start && !seq.abort) begin
          preset_d    = seq.cfg_preset;
          count_len_d = seq.cfg_count_len;
          pause_len_d = seq.cfg_pause_len;
          loops_d     = seq.cfg_loops;
          loop_d      = '0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        // len holds "clocks remaining minus one" so a full-scale length never wraps.
        if (count_len_q != '0) begin
          state_d = S_COUNT;
          len_d   = count_len_q - LEN_W'(1);
        end else if (pause_len_q != '0) begin
          state_d = S_PAUSE;
          len_d   = pause_len_q - LEN_W'(1);
        end else begin
          end_of_loop = 1'b1;
        end
      end
      S_COUNT: begin
        if (len_q != '0) begin
          len_d = len_q - LEN_W'(1);
        end else if (pause_len_q != '0) begin
          state_d = S_PAUSE;
          len_d   = pause_len_q - LEN_W'(1);
        end else begin
          end_of_loop = 1'b1;
        end
      end
      S_PAUSE: begin
        if (len_q != '0) begin
          len_d = len_q - LEN_W'(1);
        end else begin
          end_of_loop = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (end_of_loop) begin
      loop_d  = loop_inc;
      state_d = (loop_inc == loops_eff) ? S_DONE : S_LOAD;
    end

    // Abort wins over everything once a program is underway; done is never pulsed.
    if (seq.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end

    count_up_d    = (state_d == S_COUNT);
    load_d        = (state_d == S_LOAD);
    data_preset_d = (state_d == S_LOAD) ? preset_d : '0;
    busy_d        = (state_d == S_LOAD) || (state_d == S_COUNT) || (state_d == S_PAUSE);
    done_d        = (state_d == S_DONE);
  end

  // State, counters, shadow config and all outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      loop_q        <= '0;
      preset_q      <= '0;
      count_len_q   <= '0;
      pause_len_q   <= '0;
      loops_q       <= '0;
      count_up_q    <= 1'b0;
      load_q        <= 1'b0;
      data_preset_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      loop_q        <= loop_d;
      preset_q      <= preset_d;
      count_len_q   <= count_len_d;
      pause_len_q   <= pause_len_d;
      loops_q       <= loops_d;
      count_up_q    <= count_up_d;
      load_q        <= load_d;
      data_preset_q <= data_preset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign seq.count_up    = count_up_q;
  assign seq.load        = load_q;
  assign seq.data_preset = data_preset_q;
  assign seq.busy        = busy_q;
  assign seq.done        = done_q;

endmodule

// File: tb/tb_counter_preset_seq.sv
// tb/tb_counter_preset_seq.sv - directed self-checking bench for counter_preset_seq
module tb_counter_preset_seq;

  logic clk;
  logic rst;

  counter_preset_seq_if #(.WIDTH(8), .LEN_W(8), .LOOP_W(4)) bus ();

  counter_preset_seq #(.WIDTH(8), .LEN_W(8), .LOOP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .seq (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;

  // Per-cycle observation of DUT outputs plus a model of the downstream counter.
  int cyc = 0;
  int n_load = 0, n_cup = 0, n_done = 0, n_busy = 0, n_rise = 0, dp_bad = 0;
  int last_load = 0, last_done = 0, last_cup = 0, rise_cyc = 0;
  int load_hist[$];
  logic [7:0] model_cnt = 8'd0;
  bit cup_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.load === 1'b1) begin
      n_load++;
      last_load = cyc;
      load_hist.push_back(cyc);
      model_cnt = bus.data_preset;
    end else if (bus.count_up === 1'b1) begin
      model_cnt = model_cnt + 8'd1;
    end
    if (bus.count_up === 1'b1) begin
      n_cup++;
      last_cup = cyc;
      if (!cup_prev) begin
        n_rise++;
        rise_cyc = cyc;
      end
    end
    cup_prev = (bus.count_up === 1'b1);
    if (bus.done === 1'b1) begin
      n_done++;
      last_done = cyc;
    end
    if (bus.busy === 1'b1) n_busy++;
    if ((bus.load !== 1'b1) && (bus.data_preset !== 8'd0)) dp_bad++;
  end

  int s_load, s_cup, s_done, s_busy, s_rise, s_dp, s_hist;

  task automatic snap();
    s_load = n_load; s_cup = n_cup; s_done = n_done; s_busy = n_busy;
    s_rise = n_rise; s_dp = dp_bad; s_hist = load_hist.size();
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic program_cfg(input logic [7:0] p, input logic [7:0] c,
                             input logic [7:0] ps, input logic [3:0] l);
    bus.cfg_preset    = p;
    bus.cfg_count_len = c;
    bus.cfg_pause_len = ps;
    bus.cfg_loops     = l;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (bus.busy === 1'b0 && bus.done === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    vec++;
    if (!ok) begin
      err++;
      $display("FAIL wait_idle: busy=%b done=%b after %0d cycles, required idle", bus.busy, bus.done, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'($urandom); bus.abort = 1'($urandom);
    program_cfg(8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
    tick(); tick();
    vec++;
    if ({bus.count_up, bus.load, bus.data_preset, bus.busy, bus.done} !== 12'd0) begin
      err++;
      $display("FAIL reset_outputs: got %b, required 0", {bus.count_up, bus.load, bus.data_preset, bus.busy, bus.done});
    end
    bus.start = 1'b0; bus.abort = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vec++;
      if ({bus.count_up, bus.load, bus.data_preset, bus.busy, bus.done} !== 12'd0) begin
        err++;
        $display("FAIL idle_after_reset[%0d]: got %b, required 0", i, {bus.count_up, bus.load, bus.data_preset, bus.busy, bus.done});
      end
    end
  endtask

  task automatic test_basic();
    program_cfg(8'd13, 8'd20, 8'd5, 4'd1);
    snap();
    pulse_start();
    vec++;
    if (bus.load !== 1'b1 || bus.data_preset !== 8'd13 || bus.busy !== 1'b1) begin
      err++;
      $display("FAIL basic_first_load: load=%b dp=%0d busy=%b, required 1/13/1", bus.load, bus.data_preset, bus.busy);
    end
    wait_idle(60);
    vec++; if (n_load - s_load !== 1) begin err++; $display("FAIL basic_loads: got %0d, required 1", n_load - s_load); end
    vec++; if (n_cup - s_cup !== 20) begin err++; $display("FAIL basic_count_clocks: got %0d, required 20", n_cup - s_cup); end
    vec++; if (n_rise - s_rise !== 1) begin err++; $display("FAIL basic_count_runs: got %0d, required 1", n_rise - s_rise); end
    vec++; if (rise_cyc !== last_load + 1) begin err++; $display("FAIL basic_count_start: got %0d, required %0d", rise_cyc, last_load + 1); end
    vec++; if (last_cup !== last_load + 20) begin err++; $display("FAIL basic_count_end: got %0d, required %0d", last_cup, last_load + 20); end
    vec++; if (n_done - s_done !== 1) begin err++; $display("FAIL basic_done_pulses: got %0d, required 1", n_done - s_done); end
    vec++; if (last_done !== last_load + 26) begin err++; $display("FAIL basic_done_time: got %0d, required %0d", last_done, last_load + 26); end
    vec++; if (n_busy - s_busy !== 26) begin err++; $display("FAIL basic_busy_clocks: got %0d, required 26", n_busy - s_busy); end
    vec++; if (model_cnt !== 8'd33) begin err++; $display("FAIL basic_counter: got %0d, required 33", model_cnt); end
    vec++; if (dp_bad !== s_dp) begin err++; $display("FAIL basic_preset_leak: got %0d, required %0d", dp_bad, s_dp); end
  endtask

  task automatic test_loops();
    program_cfg(8'd2, 8'd3, 8'd2, 4'd3);
    snap();
    pulse_start();
    wait_idle(60);
    vec++; if (n_load - s_load !== 3) begin err++; $display("FAIL loops_loads: got %0d, required 3", n_load - s_load); end
    if (load_hist.size() >= s_hist + 3) begin
      vec++; if (load_hist[s_hist+1] - load_hist[s_hist] !== 6) begin err++; $display("FAIL loops_gap1: got %0d, required 6", load_hist[s_hist+1] - load_hist[s_hist]); end
      vec++; if (load_hist[s_hist+2] - load_hist[s_hist+1] !== 6) begin err++; $display("FAIL loops_gap2: got %0d, required 6", load_hist[s_hist+2] - load_hist[s_hist+1]); end
    end
    vec++; if (n_cup - s_cup !== 9) begin err++; $display("FAIL loops_count_clocks: got %0d, required 9", n_cup - s_cup); end
    vec++; if (n_done - s_done !== 1) begin err++; $display("FAIL loops_done_pulses: got %0d, required 1", n_done - s_done); end
    vec++; if (n_busy - s_busy !== 18) begin err++; $display("FAIL loops_busy_clocks: got %0d, required 18", n_busy - s_busy); end
    vec++; if (model_cnt !== 8'd5) begin err++; $display("FAIL loops_counter: got %0d, required 5", model_cnt); end
  endtask

  task automatic test_zero_fields();
    program_cfg(8'd77, 8'd0, 8'd0, 4'd0);
    snap();
    pulse_start();
    wait_idle(20);
    vec++; if (n_load - s_load !== 1) begin err++; $display("FAIL zero_loads: got %0d, required 1", n_load - s_load); end
    vec++; if (n_cup - s_cup !== 0) begin err++; $display("FAIL zero_count_clocks: got %0d, required 0", n_cup - s_cup); end
    vec++; if (n_done - s_done !== 1) begin err++; $display("FAIL zero_done_pulses: got %0d, required 1", n_done - s_done); end
    vec++; if (last_done !== last_load + 1) begin err++; $display("FAIL zero_done_time: got %0d, required %0d", last_done, last_load + 1); end
    vec++; if (n_busy - s_busy !== 1) begin err++; $display("FAIL zero_busy_clocks: got %0d, required 1", n_busy - s_busy); end
  endtask

  task automatic test_full_length();
    program_cfg(8'd7, 8'd255, 8'd0, 4'd1);
    snap();
    pulse_start();
    wait_idle(300);
    vec++; if (n_cup - s_cup !== 255) begin err++; $display("FAIL full_count_clocks: got %0d, required 255", n_cup - s_cup); end
    vec++; if (n_busy - s_busy !== 256) begin err++; $display("FAIL full_busy_clocks: got %0d, required 256", n_busy - s_busy); end
    vec++; if (last_done !== last_load + 256) begin err++; $display("FAIL full_done_time: got %0d, required %0d", last_done, last_load + 256); end
    vec++; if (model_cnt !== 8'd6) begin err++; $display("FAIL full_counter: got %0d, required 6", model_cnt); end
  endtask

  task automatic test_abort();
    bit hit = 1'b0;
    program_cfg(8'd13, 8'd20, 8'd5, 4'd1);
    snap();
    pulse_start();
    for (int k = 0; k < 30; k++) begin
      tick();
      if (n_cup - s_cup == 7) begin hit = 1'b1; break; end
    end
    vec++; if (!hit) begin err++; $display("FAIL abort_reach_7th: got %0d count clocks, required 7", n_cup - s_cup); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    vec++;
    if (bus.count_up !== 1'b0 || bus.busy !== 1'b0 || bus.load !== 1'b0) begin
      err++;
      $display("FAIL abort_to_idle: count_up=%b busy=%b load=%b, required 0/0/0", bus.count_up, bus.busy, bus.load);
    end
    repeat (30) tick();
    vec++; if (n_done - s_done !== 0) begin err++; $display("FAIL abort_no_done: got %0d, required 0", n_done - s_done); end
    vec++; if (model_cnt !== 8'd20) begin err++; $display("FAIL abort_counter: got %0d, required 20", model_cnt); end
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    vec++;
    if (bus.load !== 1'b0 || bus.busy !== 1'b0) begin
      err++;
      $display("FAIL abort_beats_start: load=%b busy=%b, required 0/0", bus.load, bus.busy);
    end
  endtask

  task automatic test_busy_guard();
    bit seen = 1'b0;
    program_cfg(8'd13, 8'd20, 8'd5, 4'd1);
    snap();
    pulse_start();
    repeat (5) tick();
    bus.cfg_preset = 8'd99;
    pulse_start();
    repeat (16) tick();
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done === 1'b1) begin seen = 1'b1; break; end
    end
    vec++; if (!seen) begin err++; $display("FAIL guard_done_seen: done=%b, required 1", bus.done); end
    pulse_start();
    vec++;
    if (bus.load !== 1'b0 || bus.busy !== 1'b0) begin
      err++;
      $display("FAIL guard_start_in_done: load=%b busy=%b, required 0/0", bus.load, bus.busy);
    end
    repeat (3) tick();
    vec++; if (n_load - s_load !== 1) begin err++; $display("FAIL guard_loads: got %0d, required 1", n_load - s_load); end
    vec++; if (n_cup - s_cup !== 20) begin err++; $display("FAIL guard_count_clocks: got %0d, required 20", n_cup - s_cup); end
    vec++; if (last_done !== last_load + 26) begin err++; $display("FAIL guard_done_time: got %0d, required %0d", last_done, last_load + 26); end
    vec++; if (n_busy - s_busy !== 26) begin err++; $display("FAIL guard_busy_clocks: got %0d, required 26", n_busy - s_busy); end
    vec++; if (model_cnt !== 8'd33) begin err++; $display("FAIL guard_counter: got %0d, required 33", model_cnt); end
    pulse_start();
    vec++; if (bus.data_preset !== 8'd99) begin err++; $display("FAIL guard_new_preset: got %0d, required 99", bus.data_preset); end
    wait_idle(60);
    vec++; if (model_cnt !== 8'd119) begin err++; $display("FAIL guard_new_counter: got %0d, required 119", model_cnt); end
  endtask

  task automatic test_async_reset();
    program_cfg(8'd13, 8'd20, 8'd5, 4'd1);
    snap();
    pulse_start();
    repeat (4) tick();
    #1 rst = 1'b1;
    #1;
    vec++;
    if ({bus.count_up, bus.load, bus.data_preset, bus.busy, bus.done} !== 12'd0) begin
      err++;
      $display("FAIL async_reset_outputs: got %b, required 0", {bus.count_up, bus.load, bus.data_preset, bus.busy, bus.done});
    end
    tick();
    rst = 1'b0;
    repeat (30) tick();
    vec++; if (n_done - s_done !== 0 || bus.busy !== 1'b0) begin err++; $display("FAIL async_reset_idle: done=%0d busy=%b, required 0/0", n_done - s_done, bus.busy); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    program_cfg(8'd0, 8'd0, 8'd0, 4'd0);
    test_reset();
    test_basic();
    test_loops();
    test_zero_fields();
    test_full_length();
    test_abort();
    test_busy_guard();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
